// File: rtl/apb_cordic_queue.sv
// APB-fronted command/result queue around an external CORDIC engine.
// Optional watchdog on the engine wait is compiled in with CORDIC_TIMEOUT_EN.
module apb_cordic_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [5:0]    PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          INT,
    output logic          eng_start,
    output logic [2:0]    eng_func,
    output logic [DW-1:0] eng_a,
    output logic [DW-1:0] eng_b,
    output logic [DW-1:0] eng_c,
    output logic [DW-1:0] eng_d,
    input  logic          eng_done,
    input  logic [DW-1:0] eng_out1,
    input  logic [DW-1:0] eng_out2,
    input  logic [DW-1:0] eng_out3,
    input  logic [DW-1:0] eng_out4,
    input  logic [DW-1:0] eng_out5,
    input  logic [DW-1:0] eng_out6
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StStore} state_e;

    state_e state_q, state_d;

    // APB decode; only word-aligned addresses hit a register
    logic       apb_wr, aligned;
    logic [3:0] word;
    logic       wr_ctrl, wr_status, wr_cmd, wr_pop, flush;

    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign aligned   = (PADDR[1:0] == 2'b00);
    assign word      = PADDR[5:2];
    assign wr_ctrl   = apb_wr & aligned & (word == 4'd0);
    assign wr_status = apb_wr & aligned & (word == 4'd1);
    assign wr_cmd    = apb_wr & aligned & (word == 4'd6);
    assign wr_pop    = apb_wr & aligned & (word == 4'd14);
    assign flush     = wr_ctrl & PWDATA[2];

    logic          en_q, irq_en_q;
    logic [DW-1:0] ops_q [4];
    logic          ovf_q, unf_q, tmo_q, int_q;
    logic          discard_q, discard_d;
    logic          timeout;

    // Command FIFO
    logic [2:0]    cmd_func [DEPTH];
    logic [DW-1:0] cmd_ops  [4][DEPTH];
    logic [AW-1:0] cmd_wptr_q, cmd_rptr_q;
    logic [CW-1:0] cmd_cnt_q;
    logic          cmd_full, cmd_empty, cmd_push, cmd_pop;

    assign cmd_full  = (cmd_cnt_q == CW'(DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign cmd_push  = wr_cmd & ~cmd_full;
    assign cmd_pop   = (state_q == StIssue) & ~cmd_empty;

    // Result FIFO
    logic [DW-1:0] res_mem [6][DEPTH];
    logic [DW-1:0] res_cap_q [6];
    logic [DW-1:0] eng_out_v [6];
    logic [AW-1:0] res_wptr_q, res_rptr_q;
    logic [CW-1:0] res_cnt_q;
    logic          res_full, res_empty, res_push, res_pop;

    assign res_full  = (res_cnt_q == CW'(DEPTH));
    assign res_empty = (res_cnt_q == '0);
    assign res_push  = (state_q == StStore) & ~flush;
    assign res_pop   = wr_pop & ~res_empty;

    assign eng_out_v[0] = eng_out1;
    assign eng_out_v[1] = eng_out2;
    assign eng_out_v[2] = eng_out3;
    assign eng_out_v[3] = eng_out4;
    assign eng_out_v[4] = eng_out5;
    assign eng_out_v[5] = eng_out6;

    // FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en_q && !cmd_empty && !res_full) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (eng_done) state_d = (discard_q || flush) ? StIdle : StStore;
                else if (timeout) state_d = StIdle;
            end
            StStore: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A flush while an operation is in flight marks its result for discard
    assign discard_d = ((state_q == StIssue) || (state_q == StWait)) && (discard_q || flush);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Engine operands latch on the IDLE->ISSUE decision and hold through WAIT
    logic [2:0]    eng_func_q;
    logic [DW-1:0] eng_ops_q [4];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            eng_func_q <= '0;
            for (int k = 0; k < 4; k++) eng_ops_q[k] <= '0;
            for (int k = 0; k < 6; k++) res_cap_q[k] <= '0;
        end else begin
            if (state_q == StIdle && state_d == StIssue) begin
                eng_func_q <= cmd_func[cmd_rptr_q];
                for (int k = 0; k < 4; k++) eng_ops_q[k] <= cmd_ops[k][cmd_rptr_q];
            end
            if (state_q == StWait && eng_done) begin
                for (int k = 0; k < 6; k++) res_cap_q[k] <= eng_out_v[k];
            end
        end
    end

    assign eng_start = (state_q == StIssue);
    assign eng_func  = eng_func_q;
    assign eng_a     = eng_ops_q[0];
    assign eng_b     = eng_ops_q[1];
    assign eng_c     = eng_ops_q[2];
    assign eng_d     = eng_ops_q[3];

    // Control and staging registers, sticky flags
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            int_q    <= 1'b0;
            for (int k = 0; k < 4; k++) ops_q[k] <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= PWDATA[0];
                irq_en_q <= PWDATA[1];
            end
            for (int k = 0; k < 4; k++) begin
                if (apb_wr && aligned && word == 4'(k + 2)) ops_q[k] <= DW'(PWDATA);
            end
            if (wr_cmd && cmd_full) ovf_q <= 1'b1;
            else if (wr_status && PWDATA[11]) ovf_q <= 1'b0;
            if (wr_pop && res_empty) unf_q <= 1'b1;
            else if (wr_status && PWDATA[12]) unf_q <= 1'b0;
            int_q <= irq_en_q & ((res_cnt_q != '0) | ovf_q | unf_q | tmo_q);
        end
    end

    assign INT = int_q;

`ifdef CORDIC_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;

    assign timeout = (state_q == StWait) && !eng_done && (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == StWait) ? tmo_cnt_q + 1'b1 : '0;
            if (timeout) tmo_q <= 1'b1;
            else if (wr_status && PWDATA[13]) tmo_q <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
    assign tmo_q   = 1'b0;
`endif

    // FIFO pointers; flush wins over any same-cycle push or pop
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
            res_wptr_q <= '0;
            res_rptr_q <= '0;
            res_cnt_q  <= '0;
        end else if (flush) begin
            cmd_wptr_q <= '0;
            cmd_rptr_q <= '0;
            cmd_cnt_q  <= '0;
            res_wptr_q <= '0;
            res_rptr_q <= '0;
            res_cnt_q  <= '0;
        end else begin
            if (cmd_push) cmd_wptr_q <= cmd_wptr_q + 1'b1;
            if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + 1'b1;
            cmd_cnt_q <= cmd_cnt_q + CW'(cmd_push) - CW'(cmd_pop);
            if (res_push) res_wptr_q <= res_wptr_q + 1'b1;
            if (res_pop)  res_rptr_q <= res_rptr_q + 1'b1;
            res_cnt_q <= res_cnt_q + CW'(res_push) - CW'(res_pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (cmd_push) begin
            cmd_func[cmd_wptr_q] <= PWDATA[2:0];
            for (int k = 0; k < 4; k++) cmd_ops[k][cmd_wptr_q] <= ops_q[k];
        end
        if (res_push) begin
            for (int k = 0; k < 6; k++) res_mem[k][res_wptr_q] <= res_cap_q[k];
        end
    end

    // Read mux
    logic [31:0] status;

    assign status = {18'b0, tmo_q, unf_q, ovf_q, (state_q != StIdle),
                     5'(res_cnt_q), 5'(cmd_cnt_q)};

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE && aligned) begin
            case (word)
                4'd0:  PRDATA = {30'b0, irq_en_q, en_q};
                4'd1:  PRDATA = status;
                4'd2:  PRDATA = 32'(ops_q[0]);
                4'd3:  PRDATA = 32'(ops_q[1]);
                4'd4:  PRDATA = 32'(ops_q[2]);
                4'd5:  PRDATA = 32'(ops_q[3]);
                4'd8:  if (!res_empty) PRDATA = 32'(res_mem[0][res_rptr_q]);
                4'd9:  if (!res_empty) PRDATA = 32'(res_mem[1][res_rptr_q]);
                4'd10: if (!res_empty) PRDATA = 32'(res_mem[2][res_rptr_q]);
                4'd11: if (!res_empty) PRDATA = 32'(res_mem[3][res_rptr_q]);
                4'd12: if (!res_empty) PRDATA = 32'(res_mem[4][res_rptr_q]);
                4'd13: if (!res_empty) PRDATA = 32'(res_mem[5][res_rptr_q]);
                default: PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cordic_queue.sv
// Directed self-checking bench for apb_cordic_queue (DEPTH=4, TIMEOUT=20).
module tb_apb_cordic_queue;

    localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_OPA = 6'h08, A_OPB = 6'h0C;
    localparam logic [5:0] A_CMD = 6'h18, A_RES0 = 6'h20, A_POP = 6'h38;

    logic        PCLK = 0, PRESET = 1;
    logic        PSEL = 0, PENABLE = 0, PWRITE = 0;
    logic [5:0]  PADDR = 0;
    logic [31:0] PWDATA = 0, PRDATA;
    logic        INT, eng_start, eng_done = 0;
    logic [2:0]  eng_func;
    logic [31:0] eng_a, eng_b, eng_c, eng_d;
    logic [31:0] eng_out1 = 0, eng_out2 = 0, eng_out3 = 0, eng_out4 = 0, eng_out5 = 0,
                 eng_out6 = 0;

    int checks = 0;
    int fails  = 0;

    apb_cordic_queue #(.DEPTH(4), .DW(32), .TIMEOUT(20)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .INT(INT),
        .eng_start(eng_start), .eng_func(eng_func), .eng_a(eng_a), .eng_b(eng_b),
        .eng_c(eng_c), .eng_d(eng_d), .eng_done(eng_done),
        .eng_out1(eng_out1), .eng_out2(eng_out2), .eng_out3(eng_out3),
        .eng_out4(eng_out4), .eng_out5(eng_out5), .eng_out6(eng_out6)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        #2;
        d = PRDATA;
        PSEL = 0;
    endtask

    // Returns the number of cycles until eng_start is seen, -1 if never within bound
    task automatic wait_start(input int bound, output int cyc);
        cyc = -1;
        for (int i = 0; i <= bound; i++) begin
            if (eng_start === 1'b1) begin
                cyc = i;
                break;
            end
            if (i < bound) begin
                @(posedge PCLK); #1;
            end
        end
    endtask

    // Called in the eng_start cycle; checks the pulse width, then answers after lat cycles
    task automatic finish_engine(input int lat, input logic [31:0] o1);
        @(posedge PCLK); #1;
        checks++;
        if (eng_start !== 1'b0) begin
            fails++;
            $display("FAIL start_width: eng_start=%b required 0", eng_start);
        end
        repeat (lat - 1) begin
            @(posedge PCLK); #1;
        end
        eng_done = 1; eng_out1 = o1;
        @(posedge PCLK); #1;
        eng_done = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        PRESET = 1;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (INT !== 1'b0 || eng_start !== 1'b0 || eng_func !== 3'd0 || eng_a !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: INT=%b start=%b func=%h a=%h required 0",
                     INT, eng_start, eng_func, eng_a);
        end
        PRESET = 0;
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h required 0", d); end
        apb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h required 0", d); end
        apb_read(A_OPA, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_opa: got %h required 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int cyc;
        apb_write(A_CTRL, 32'h1);
        apb_write(A_OPA, 32'h10000);
        apb_write(A_OPB, 32'h1234);
        apb_read(A_OPB, d);
        checks++;
        if (d !== 32'h1234) begin fails++; $display("FAIL opb_rw: got %h required 1234", d); end
        apb_write(A_CMD, 32'h1);
        wait_start(10, cyc);
        checks++;
        if (cyc !== 1) begin fails++; $display("FAIL basic_issue_latency: got %0d required 1", cyc); end
        checks++;
        if (eng_func !== 3'd1 || eng_a !== 32'h10000 || eng_b !== 32'h1234) begin
            fails++;
            $display("FAIL basic_operands: func=%h a=%h b=%h required 1 10000 1234",
                     eng_func, eng_a, eng_b);
        end
        finish_engine(5, 32'hAA);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h20) begin fails++; $display("FAIL basic_status: got %h required 20", d); end
        apb_read(A_RES0, d);
        checks++;
        if (d !== 32'hAA) begin fails++; $display("FAIL basic_res0: got %h required aa", d); end
        apb_write(A_POP, 32'h0);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL basic_pop_status: got %h required 0", d); end
        apb_read(A_RES0, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL basic_res0_empty: got %h required 0", d); end
    endtask

    task automatic test_cmd_overflow();
        logic [31:0] d;
        apb_write(A_CTRL, 32'h0);
        for (int i = 0; i < 5; i++) apb_write(A_CMD, 32'(i));
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h804) begin fails++; $display("FAIL ovf_status: got %h required 804", d); end
        apb_write(A_STATUS, 32'h800);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h004) begin fails++; $display("FAIL ovf_clear: got %h required 004", d); end
        apb_write(A_CTRL, 32'h4);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL ovf_flush: got %h required 0", d); end
        apb_read(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL flush_selfclear: got %h required 0", d); end
    endtask

    task automatic test_res_underflow();
        logic [31:0] d;
        apb_write(A_CTRL, 32'h2);
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (INT !== 1'b0) begin fails++; $display("FAIL unf_int_idle: got %b required 0", INT); end
        apb_write(A_POP, 32'h0);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h1000) begin fails++; $display("FAIL unf_status: got %h required 1000", d); end
        checks++;
        if (INT !== 1'b1) begin fails++; $display("FAIL unf_int: got %b required 1", INT); end
        apb_write(A_STATUS, 32'h1000);
        repeat (2) @(posedge PCLK);
        #1;
        checks++;
        if (INT !== 1'b0) begin fails++; $display("FAIL unf_int_clear: got %b required 0", INT); end
        apb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_result_full();
        logic [31:0] d;
        logic [31:0] exp_res [4];
        int cyc;
        bit seen;
        apb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) begin
            apb_write(A_CMD, 32'(i));
            wait_start(10, cyc);
            checks++;
            if (cyc !== 1) begin fails++; $display("FAIL fill_issue_%0d: got %0d required 1", i, cyc); end
            finish_engine(2, 32'h101 + 32'(i));
        end
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h80) begin fails++; $display("FAIL fill_status: got %h required 80", d); end
        apb_write(A_CMD, 32'h5);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge PCLK); #1;
            if (eng_start === 1'b1) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin fails++; $display("FAIL full_blocks_issue: start seen=%b required 0", seen); end
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h81) begin fails++; $display("FAIL full_pending: got %h required 81", d); end
        apb_write(A_POP, 32'h0);
        wait_start(3, cyc);
        checks++;
        if (cyc !== 1) begin fails++; $display("FAIL issue_after_pop: got %0d required 1", cyc); end
        finish_engine(2, 32'h200);
        exp_res[0] = 32'h102; exp_res[1] = 32'h103; exp_res[2] = 32'h104; exp_res[3] = 32'h200;
        for (int i = 0; i < 4; i++) begin
            apb_read(A_RES0, d);
            checks++;
            if (d !== exp_res[i]) begin
                fails++;
                $display("FAIL wrap_res_%0d: got %h required %h", i, d, exp_res[i]);
            end
            apb_write(A_POP, 32'h0);
        end
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL drain_status: got %h required 0", d); end
        apb_write(A_CTRL, 32'h0);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int cyc;
        apb_write(A_CTRL, 32'h1);
        apb_write(A_CMD, 32'h2);
        wait_start(10, cyc);
        checks++;
        if (cyc !== 1) begin fails++; $display("FAIL tmo_issue: got %0d required 1", cyc); end
`ifdef CORDIC_TIMEOUT_EN
        repeat (5) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h400) begin fails++; $display("FAIL tmo_busy: got %h required 400", d); end
        repeat (25) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h2000) begin fails++; $display("FAIL tmo_status: got %h required 2000", d); end
        apb_write(A_STATUS, 32'h2000);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL tmo_clear: got %h required 0", d); end
        apb_write(A_CTRL, 32'h0);
`else
        repeat (40) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h400) begin fails++; $display("FAIL no_tmo_status: got %h required 400", d); end
        apb_write(A_CTRL, 32'h4);
        @(posedge PCLK); #1;
        eng_done = 1;
        @(posedge PCLK); #1;
        eng_done = 0;
        repeat (2) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL no_tmo_recover: got %h required 0", d); end
`endif
    endtask

    task automatic test_flush_wait();
        logic [31:0] d;
        apb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 4; i++) apb_write(A_CMD, 32'(i));
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h403) begin fails++; $display("FAIL flush_pre: got %h required 403", d); end
        apb_write(A_CTRL, 32'h4);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h400) begin fails++; $display("FAIL flush_counts: got %h required 400", d); end
        @(posedge PCLK); #1;
        eng_done = 1; eng_out1 = 32'hDEAD;
        @(posedge PCLK); #1;
        eng_done = 0;
        repeat (3) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL flush_late_done: got %h required 0", d); end
        apb_read(A_RES0, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL flush_res0: got %h required 0", d); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] d;
        int cyc;
        apb_write(A_CTRL, 32'h1);
        apb_write(A_OPA, 32'h55);
        apb_write(A_CMD, 32'h3);
        wait_start(10, cyc);
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1;
        #1;
        checks++;
        if (eng_func !== 3'd0 || eng_a !== 32'd0 || eng_start !== 1'b0) begin
            fails++;
            $display("FAIL midwait_reset_outputs: func=%h a=%h start=%b required 0",
                     eng_func, eng_a, eng_start);
        end
        @(posedge PCLK); #1;
        PRESET = 0;
        eng_done = 1;
        @(posedge PCLK); #1;
        eng_done = 0;
        repeat (2) @(posedge PCLK);
        apb_read(A_STATUS, d);
        checks++;
        if (d !== 32'h0) begin fails++; $display("FAIL midwait_status: got %h required 0", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cmd_overflow();
        test_res_underflow();
        test_result_full();
        test_timeout();
        test_flush_wait();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/apb_cordic_queue.md
APB_CORDIC_QUEUE -- requirements
Module: apb_cordic_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command- and result-FIFO depth, power of two, 2..16.
REQ-002 SHALL have parameter DW, default 32, operand/result word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, watchdog limit in cycles.
REQ-004 SHALL have ports PCLK in 1 clock; PRESET in 1 reset, asynchronous, active-high (one clock, no other reset).
REQ-005 SHALL have ports PSEL, PENABLE, PWRITE in 1; PADDR in 6; PWDATA in 32; PRDATA out 32; INT out 1.
REQ-006 SHALL have engine ports eng_start out 1, one-cycle start pulse; eng_func out 3; eng_a..eng_d out DW each; eng_done in 1, one-cycle pulse; eng_out1..eng_out6 in DW each.

Function
REQ-007 SHALL write on PSEL&PENABLE&PWRITE, zero wait states; PRDATA SHALL be combinational from PADDR while PSEL&!PWRITE, else 0.
REQ-008 SHALL map: 0x00 CTRL[0]=EN, [1]=IRQ_EN, [2]=FLUSH (self-clearing, reads 0); 0x04 STATUS; 0x08..0x14 OPA..OPD staging RW.
REQ-009 SHALL map: 0x18 CMD write-only, push {PWDATA[2:0], OPA..OPD} to command FIFO; 0x20..0x34 RES0..RES5 read head result entry; 0x38 POP write-only, any write pops result FIFO.
REQ-010 SHALL encode STATUS: [4:0] cmd count, [9:5] result count, [10] busy (FSM not IDLE), [11] CMD_OVF, [12] RES_UNF, [13] TMO; bits 11..13 sticky, cleared by writing 1 to STATUS.
REQ-011 SHALL run FSM IDLE->ISSUE->WAIT->STORE->IDLE; IDLE->ISSUE only when EN=1, command FIFO non-empty, result FIFO not full.
REQ-012 SHALL, in ISSUE, pop the command head, drive eng_func/eng_a..d from it, and assert eng_start for exactly one cycle.
REQ-013 SHALL hold eng_func/eng_a..d stable from ISSUE until leaving WAIT.
REQ-014 SHALL, in WAIT, capture eng_out1..6 on eng_done and go to STORE; STORE SHALL push the captured entry into the result FIFO in one cycle; eng_done outside WAIT SHALL be ignored.
REQ-015 SHALL give minimum command-to-result latency of CMD write + 3 cycles + engine latency.
REQ-016 SHALL drop a CMD write when command FIFO full, set CMD_OVF; SHALL ignore a POP when result FIFO empty, set RES_UNF; RES0..5 SHALL read 0 when empty.
REQ-017 SHALL allow CMD push and FSM pop of command FIFO in the same cycle, and POP with STORE push of result FIFO in the same cycle; counts SHALL stay correct when full or empty.
REQ-018 SHALL wrap FIFO pointers modulo DEPTH with no gap.
REQ-019 SHALL, on FLUSH, empty both FIFOs next cycle; if in WAIT, SHALL discard the pending result, still waiting for eng_done before IDLE.
REQ-020 SHALL clearing EN not abort an in-flight operation; only issue is blocked.
REQ-021 SHALL drive INT = IRQ_EN & (result count != 0 | CMD_OVF | RES_UNF | TMO), registered.

Reset
REQ-022 SHALL on PRESET clear CTRL, OPA..OPD, FIFOs, sticky flags, FSM to IDLE; INT, eng_start, eng_* outputs SHALL be 0; reset mid-WAIT SHALL abandon the operation.

Configuration
REQ-023 SHALL compile the watchdog only with CORDIC_TIMEOUT_EN: WAIT counts cycles; reaching TIMEOUT without eng_done sets TMO, pushes nothing, returns to IDLE; without the macro WAIT has no limit and STATUS[13] reads 0.

Verification
REQ-024 SHALL test: reset, EN=1, OPA=0x10000, func=1 CMD, engine done after 5 cycles with out1=0xAA -> eng_start one cycle, STATUS[9:5]=1, RES0=0xAA, POP -> count 0.
REQ-025 SHALL test: DEPTH=4, EN=0, 5 CMD writes -> cmd count 4, CMD_OVF=1; write 0x800 to STATUS -> bit 11 clears.
REQ-026 SHALL test: POP on empty -> RES_UNF=1, INT=1 when IRQ_EN=1, counts unchanged.
REQ-027 SHALL test: fill result FIFO (4 entries), 1 pending CMD -> no eng_start until one POP, then issue next cycle.
REQ-028 SHALL test: CORDIC_TIMEOUT_EN, TIMEOUT=20, engine never responds -> TMO=1 after 20 WAIT cycles, FSM IDLE, result count 0.
REQ-029 SHALL test: FLUSH during WAIT with 3 queued -> both counts 0, late eng_done produces no result, busy clears.
